wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbiter for the single register-file write port. Shares it between the in-order pipeline writeback (the W-stage outputs: value, destination, byte write-enable) and a multi-cycle secondary producer (divider / late load return) using a valid/ready handshake. Holds one pending secondary write, drives a registered write port into the register file, and raises a stall request to the hazard unit when the secondary write starves. The pending destination is exported so the hazard unit can block readers of that register.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive lost cycles before stall_req is raised; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  synchronous, active-low reset.
- pipe_val  in  32  pipeline writeback data.
- pipe_dst  in  5  pipeline destination register.
- pipe_we  in  4  pipeline byte write-enable; nonzero means request.
- sec_valid  in  1  secondary write offered.
- sec_ready  out  1  secondary write accepted this cycle when sec_valid is high.
- sec_val  in  32  secondary data.
- sec_dst  in  5  secondary destination.
- sec_we  in  4  secondary byte write-enable.
- rf_val  out  32  register-file write data (registered).
- rf_dst  out  5  register-file write address (registered).
- rf_we  out  4  register-file byte write-enable (registered).
- stall_req  out  1  request one pipeline bubble (registered).
- hold_busy  out  1  a secondary write is pending.
- hold_dst  out  5  destination of the pending write; 0 when not busy.

## Operation
- Pipe request: pipe_we != 0 and pipe_dst != 0. If pipe_dst == 0, the request is ignored.
- Hold buffer: one entry (val, dst, we). States:
  - EMPTY: hold_busy = 0.
  - WAIT: full, counting lost cycles.
  - STALL: full, stall_req = 1.
- Grant each cycle, in priority order:
  1. A pipe request always wins and is registered onto rf_*.
  2. Otherwise, if the hold buffer is full, the hold entry is registered onto rf_* and the hold buffer empties.
  3. Otherwise rf_we <= 0. rf_val and rf_dst keep their previous values.
- sec_ready = !hold_busy || hold granted this cycle. This is a combinational path from pipe_we and pipe_dst; it gives full throughput.
- Acceptance (sec_valid && sec_ready) loads the hold buffer at the edge. There is no bypass, so the entry is granted no earlier than the next cycle.
- Entries with sec_dst == 0 or sec_we == 0 are accepted and dropped: the hold buffer stays or becomes empty, and no write occurs.
- Starvation counter (4 bits):
  - Increments each cycle the hold buffer is full and loses to the pipe.
  - Clears on hold grant or when the buffer is empty.
  - Saturates at STARVE_LIMIT.
- WAIT→STALL: when the counter reaches STARVE_LIMIT, stall_req is 1 from the next cycle onward.
- STALL→EMPTY (or back to WAIT if a refill is accepted the same cycle): on hold grant. stall_req clears on the same edge.
- If the pipe keeps writing during STALL (bubble not honoured), the pipe still wins and stall_req stays high.
- Ordering between a pending hold write and a younger pipe write to the same register is the hazard unit's job, using hold_busy and hold_dst. This block does no address comparison.

## Timing
- Reset (resetn = 0 at posedge) gives:
  - rf_val = 0, rf_dst = 0, rf_we = 0.
  - stall_req = 0, hold_busy = 0, hold_dst = 0.
  - Counter = 0, state EMPTY.
- sec_ready is 1 in the first cycle after reset. Reset mid-operation discards the hold entry without writing it.
- Pipe latency: request in cycle t appears on rf_* in cycle t+1.
- Secondary latency, pipe quiet: accepted in t, granted in t+1, on rf_* in t+2.
- Stall timing: the hold buffer loses in cycles t .. t+STARVE_LIMIT-1, stall_req = 1 in cycle t+STARVE_LIMIT. If pipe_we == 0 in that cycle, rf_* carries the hold write in t+STARVE_LIMIT+1 and stall_req is 0 there.
- Simultaneous hold grant and new sec_valid: the new entry is accepted on the same edge, so back-to-back secondary writes run at 1 per cycle while the pipe is quiet.

## Test plan
- Reset: drive random inputs with resetn = 0 for 2 cycles. Required: all outputs 0, then sec_ready = 1.
- Pipe only: pipe_we = 4'hF, pipe_dst = 5, pipe_val = 32'h1234 at t. Required: rf_we = F, rf_dst = 5, rf_val = 1234 at t+1. With pipe_dst = 0: rf_we = 0.
- Secondary, pipe idle: sec_valid at t with dst 9, val 32'hDEAD, we F. Required: hold_busy = 1, hold_dst = 9 at t+1; rf_* = 9/DEAD/F at t+2; sec_ready = 1 throughout. Repeat with dst 0: no rf write ever.
- Conflict and starvation (STARVE_LIMIT = 4): load the hold buffer with dst 7, then keep pipe_we = F every cycle. Required: stall_req rises after 4 lost cycles and stays high while the pipe continues. Drop pipe_we to 0: dst 7 is written the next cycle, then stall_req = 0 and hold_busy = 0.
- Back-to-back secondary: 3 consecutive sec_valid with dst 1/2/3, pipe idle. Required: sec_ready = 1 each cycle; rf_dst = 1, 2, 3 on consecutive cycles.
- Reset mid-operation: hold buffer full with stall_req = 1, then assert resetn = 0. Required: the next cycle shows hold_busy = 0, stall_req = 0, rf_we = 0, and the pending write is never issued.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. one-entry secondary hold buffer.
// The pipe always wins. A starving hold entry raises stall_req so the hazard unit can
// insert a bubble, which lets the hold entry drain.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pipe_val,
  input  logic [4:0]  pipe_dst,
  input  logic [3:0]  pipe_we,
  input  logic        sec_valid,
  output logic        sec_ready,
  input  logic [31:0] sec_val,
  input  logic [4:0]  sec_dst,
  input  logic [3:0]  sec_we,
  output logic [31:0] rf_val,
  output logic [4:0]  rf_dst,
  output logic [3:0]  rf_we,
  output logic        stall_req,
  output logic        hold_busy,
  output logic [4:0]  hold_dst
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StEmpty, StWait, StStall} hold_state_e;

  hold_state_e state_q;
  logic [31:0] hold_val_q;
  logic [4:0]  hold_dst_q;
  logic [3:0]  hold_we_q;
  logic [3:0]  cnt_q;
  logic [31:0] rf_val_q;
  logic [4:0]  rf_dst_q;
  logic [3:0]  rf_we_q;
  logic        stall_req_q;

  logic       pipe_req;
  logic       hold_full;
  logic       hold_grant;
  logic       accept;
  logic       accept_keep;
  logic [3:0] cnt_inc;

  // Grant decode, handshake and saturating counter increment.
  always_comb begin
    pipe_req    = (pipe_we != 4'd0) && (pipe_dst != 5'd0);
    hold_full   = (state_q != StEmpty);
    hold_grant  = hold_full && !pipe_req;
    // A hold entry granted this cycle frees the slot, so a refill can land on the same edge.
    sec_ready   = !hold_full || hold_grant;
    accept      = sec_valid && sec_ready;
    // Entries that would write nothing are taken off the producer but never stored.
    accept_keep = accept && (sec_dst != 5'd0) && (sec_we != 4'd0);
    cnt_inc     = (cnt_q >= Limit) ? cnt_q : cnt_q + 4'd1;
  end

  // Hold-buffer FSM, starvation counter and registered write port.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StEmpty;
      hold_val_q  <= 32'd0;
      hold_dst_q  <= 5'd0;
      hold_we_q   <= 4'd0;
      cnt_q       <= 4'd0;
      rf_val_q    <= 32'd0;
      rf_dst_q    <= 5'd0;
      rf_we_q     <= 4'd0;
      stall_req_q <= 1'b0;
    end else begin
      if (pipe_req) begin
        rf_val_q <= pipe_val;
        rf_dst_q <= pipe_dst;
        rf_we_q  <= pipe_we;
      end else if (hold_full) begin
        rf_val_q <= hold_val_q;
        rf_dst_q <= hold_dst_q;
        rf_we_q  <= hold_we_q;
      end else begin
        rf_we_q  <= 4'd0;
      end

      if (accept_keep) begin
        state_q     <= StWait;
        hold_val_q  <= sec_val;
        hold_dst_q  <= sec_dst;
        hold_we_q   <= sec_we;
        cnt_q       <= 4'd0;
        stall_req_q <= 1'b0;
      end else if (hold_grant || !hold_full) begin
        state_q     <= StEmpty;
        hold_dst_q  <= 5'd0;
        hold_we_q   <= 4'd0;
        cnt_q       <= 4'd0;
        stall_req_q <= 1'b0;
      end else begin
        // Full and lost to the pipe this cycle.
        cnt_q <= cnt_inc;
        if (cnt_inc >= Limit) begin
          state_q     <= StStall;
          stall_req_q <= 1'b1;
        end
      end
    end
  end

  assign rf_val    = rf_val_q;
  assign rf_dst    = rf_dst_q;
  assign rf_we     = rf_we_q;
  assign stall_req = stall_req_q;
  assign hold_busy = hold_full;
  assign hold_dst  = hold_full ? hold_dst_q : 5'd0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: inline assertions plus an rf-write scoreboard.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pipe_val;
  logic [4:0]  pipe_dst;
  logic [3:0]  pipe_we;
  logic        sec_valid;
  logic        sec_ready;
  logic [31:0] sec_val;
  logic [4:0]  sec_dst;
  logic [3:0]  sec_we;
  logic [31:0] rf_val;
  logic [4:0]  rf_dst;
  logic [3:0]  rf_we;
  logic        stall_req;
  logic        hold_busy;
  logic [4:0]  hold_dst;

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [31:0] val;
    logic [4:0]  dst;
    logic [3:0]  we;
  } wr_t;
  wr_t exp_q[$];

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pipe_val  (pipe_val),
    .pipe_dst  (pipe_dst),
    .pipe_we   (pipe_we),
    .sec_valid (sec_valid),
    .sec_ready (sec_ready),
    .sec_val   (sec_val),
    .sec_dst   (sec_dst),
    .sec_we    (sec_we),
    .rf_val    (rf_val),
    .rf_dst    (rf_dst),
    .rf_we     (rf_we),
    .stall_req (stall_req),
    .hold_busy (hold_busy),
    .hold_dst  (hold_dst)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v, input logic [4:0] d, input logic [3:0] w);
    wr_t e;
    e.val = v;
    e.dst = d;
    e.we  = w;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_val  = 32'd0;
    pipe_dst  = 5'd0;
    pipe_we   = 4'd0;
    sec_valid = 1'b0;
    sec_val   = 32'd0;
    sec_dst   = 5'd0;
    sec_we    = 4'd0;
  endtask

  task automatic drive_pipe(input logic [31:0] v, input logic [4:0] d, input logic [3:0] w);
    pipe_val = v;
    pipe_dst = d;
    pipe_we  = w;
  endtask

  task automatic drive_sec(input logic [31:0] v, input logic [4:0] d, input logic [3:0] w);
    sec_valid = 1'b1;
    sec_val   = v;
    sec_dst   = d;
    sec_we    = w;
  endtask

  // Every rf write must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && rf_we !== 4'd0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, rf_dst, 28'd0, rf_we}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_val", 64'(rf_val), 64'(e.val));
        chk("sb_dst", 64'(rf_dst), 64'(e.dst));
        chk("sb_we", 64'(rf_we), 64'(e.we));
      end
    end
  end

  initial begin
    idle();
    resetn = 1'b0;

    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++) begin
      pipe_val  = $urandom;
      pipe_dst  = 5'($urandom);
      pipe_we   = 4'($urandom);
      sec_valid = 1'($urandom);
      sec_val   = $urandom;
      sec_dst   = 5'($urandom);
      sec_we    = 4'($urandom);
      cyc();
    end
    chk("rst_rf_val", 64'(rf_val), 64'd0);
    chk("rst_rf_dst", 64'(rf_dst), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_hold_busy", 64'(hold_busy), 64'd0);
    chk("rst_hold_dst", 64'(hold_dst), 64'd0);
    idle();
    resetn = 1'b1;
    mon_en = 1'b1;
    #1;
    chk("rst_sec_ready", 64'(sec_ready), 64'd1);

    // Pipe only.
    drive_pipe(32'h1234, 5'd5, 4'hF);
    push(32'h1234, 5'd5, 4'hF);
    cyc();
    chk("pipe_rf_we", 64'(rf_we), 64'hF);
    chk("pipe_rf_dst", 64'(rf_dst), 64'd5);
    chk("pipe_rf_val", 64'(rf_val), 64'h1234);
    drive_pipe(32'h9999, 5'd0, 4'hF);
    cyc();
    chk("pipe_dst0_we", 64'(rf_we), 64'd0);
    chk("pipe_dst0_keep_dst", 64'(rf_dst), 64'd5);
    idle();

    // Secondary with pipe idle.
    drive_sec(32'hDEAD, 5'd9, 4'hF);
    #1;
    chk("sec_ready_t", 64'(sec_ready), 64'd1);
    push(32'hDEAD, 5'd9, 4'hF);
    cyc();
    idle();
    chk("sec_hold_busy", 64'(hold_busy), 64'd1);
    chk("sec_hold_dst", 64'(hold_dst), 64'd9);
    #1;
    chk("sec_ready_t1", 64'(sec_ready), 64'd1);
    cyc();
    chk("sec_rf_dst", 64'(rf_dst), 64'd9);
    chk("sec_rf_val", 64'(rf_val), 64'hDEAD);
    chk("sec_rf_we", 64'(rf_we), 64'hF);
    chk("sec_drained", 64'(hold_busy), 64'd0);

    // Secondary to r0 is dropped.
    drive_sec(32'h5555, 5'd0, 4'hF);
    cyc();
    idle();
    chk("sec0_hold_busy", 64'(hold_busy), 64'd0);
    cyc();
    chk("sec0_rf_we_a", 64'(rf_we), 64'd0);
    cyc();
    chk("sec0_rf_we_b", 64'(rf_we), 64'd0);

    // Starvation: hold dst 7 loses to a continuous pipe stream.
    drive_sec(32'h7777, 5'd7, 4'hF);
    cyc();
    idle();
    chk("starve_busy", 64'(hold_busy), 64'd1);
    chk("starve_hold_dst", 64'(hold_dst), 64'd7);
    chk("starve_stall0", 64'(stall_req), 64'd0);
    for (int i = 0; i < 6; i++) begin
      drive_pipe(32'h100 + 32'(i), 5'd10, 4'hF);
      push(32'h100 + 32'(i), 5'd10, 4'hF);
      #1;
      chk("starve_sec_ready", 64'(sec_ready), 64'd0);
      cyc();
      chk("starve_stall", 64'(stall_req), (i >= 3) ? 64'd1 : 64'd0);
      chk("starve_busy_loop", 64'(hold_busy), 64'd1);
    end
    idle();
    push(32'h7777, 5'd7, 4'hF);
    #1;
    chk("starve_grant_ready", 64'(sec_ready), 64'd1);
    cyc();
    chk("starve_rf_dst", 64'(rf_dst), 64'd7);
    chk("starve_rf_we", 64'(rf_we), 64'hF);
    chk("starve_stall_clr", 64'(stall_req), 64'd0);
    chk("starve_busy_clr", 64'(hold_busy), 64'd0);
    chk("starve_hold_dst_clr", 64'(hold_dst), 64'd0);

    // Back-to-back secondary writes.
    for (int i = 1; i <= 3; i++) begin
      drive_sec(32'hB0 + 32'(i), 5'(i), 4'hF);
      #1;
      chk("b2b_sec_ready", 64'(sec_ready), 64'd1);
      push(32'hB0 + 32'(i), 5'(i), 4'hF);
      cyc();
      if (i >= 2) begin
        chk("b2b_rf_dst", 64'(rf_dst), 64'(i - 1));
        chk("b2b_rf_we", 64'(rf_we), 64'hF);
      end
    end
    idle();
    cyc();
    chk("b2b_rf_dst_last", 64'(rf_dst), 64'd3);
    chk("b2b_rf_we_last", 64'(rf_we), 64'hF);
    cyc();
    chk("b2b_rf_we_end", 64'(rf_we), 64'd0);

    // Reset mid-operation with a stalled hold entry.
    drive_sec(32'hCCCC, 5'd12, 4'h3);
    cyc();
    idle();
    for (int i = 0; i < 4; i++) begin
      drive_pipe(32'h200 + 32'(i), 5'd11, 4'hF);
      push(32'h200 + 32'(i), 5'd11, 4'hF);
      cyc();
    end
    chk("mid_stall", 64'(stall_req), 64'd1);
    chk("mid_busy", 64'(hold_busy), 64'd1);
    idle();
    resetn = 1'b0;
    cyc();
    chk("mid_rst_busy", 64'(hold_busy), 64'd0);
    chk("mid_rst_stall", 64'(stall_req), 64'd0);
    chk("mid_rst_rf_we", 64'(rf_we), 64'd0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mid_no_write", 64'(rf_we), 64'd0);
    end

    cyc();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
